// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the tagged memory request/response bus:
// tag field positions, line geometry, responder state type and the
// line-wrap beat offset helper.
package mem_bus_responder_pkg;

  // Tag bit that marks a request as a write (0 = read)
  localparam int TAG_WR_BIT = 12;

  // Line geometry: 8 beats of 64-bit words, 3-bit beat offset in a line
  localparam int LINE_BEATS = 8;
  localparam int LINE_OFF_W = 3;

  // Byte-offset bits below the 64-bit word index in a byte address
  localparam int WORD_OFF_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_DATA  = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_BURST = 2'd3
  } bus_state_e;

  // Word offset inside a line for beat cnt of a burst that starts at
  // start; the 3-bit sum wraps, giving critical-word-first order.
  function automatic logic [LINE_OFF_W-1:0] beat_offset(
    input logic [LINE_OFF_W-1:0] start,
    input logic [LINE_OFF_W-1:0] cnt
  );
    return start + cnt;
  endfunction

endpackage

// File: rtl/mem_bus_store.sv
// Word-addressed backing store: single port, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module mem_bus_store #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 65536
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store one word on a write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the tagged 64-bit bus. Accepts one line
// transaction at a time: writes take an address beat plus 8 data beats,
// reads return an 8-beat critical-word-first burst after a fixed latency.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 65536,
  parameter int READ_LATENCY   = 4,
  parameter int BEATS          = LINE_BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int BASE_W = ADDR_W - LINE_OFF_W;
  localparam int WAIT_W = $clog2(READ_LATENCY + 1);
  localparam logic [LINE_OFF_W-1:0] LAST_BEAT = LINE_OFF_W'(BEATS - 1);

  bus_state_e                state_r;
  logic [BASE_W-1:0]         base_r;
  logic [LINE_OFF_W-1:0]     start_r;
  logic [LINE_OFF_W-1:0]     cnt_r;
  logic [WAIT_W-1:0]         wait_r;
  logic [BUS_TAG_WIDTH-1:0]  tag_r;

  logic                      req_xfer_s;
  logic [ADDR_W-1:0]         idx_s;
  logic [LINE_OFF_W-1:0]     beat_sel_s;
  logic [ADDR_W-1:0]         mem_addr_s;
  logic                      mem_we_s;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata_s;

  // Only IDLE (address beat) and WR_DATA (data beats) take request beats
  assign bus_reqack = bus_reqcyc && ((state_r == ST_IDLE) || (state_r == ST_WR_DATA));
  assign req_xfer_s = bus_reqcyc && bus_reqack;

  // Byte address to word index; bits above the store size wrap away
  assign idx_s = bus_req[WORD_OFF_W +: ADDR_W];

  // Beat whose word the store port addresses: the current write beat, or
  // the read beat that loads into the output register on the next edge
  always_comb begin
    beat_sel_s = {LINE_OFF_W{1'b0}};
    case (state_r)
      ST_WR_DATA:  beat_sel_s = cnt_r;
      ST_RD_BURST: beat_sel_s = cnt_r + LINE_OFF_W'(1);
      default:     beat_sel_s = {LINE_OFF_W{1'b0}};
    endcase
  end

  assign mem_addr_s = {base_r, beat_offset(start_r, beat_sel_s)};
  assign mem_we_s   = req_xfer_s && (state_r == ST_WR_DATA);

  mem_bus_store #(
    .WIDTH (BUS_DATA_WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_store (
    .clk   (clk),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (bus_req),
    .rdata (mem_rdata_s)
  );

  // Transaction FSM: captures requests, counts write beats and read
  // latency, and drives the registered response beat and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      base_r      <= {BASE_W{1'b0}};
      start_r     <= {LINE_OFF_W{1'b0}};
      cnt_r       <= {LINE_OFF_W{1'b0}};
      wait_r      <= {WAIT_W{1'b0}};
      tag_r       <= {BUS_TAG_WIDTH{1'b0}};
      bus_respcyc <= 1'b0;
      bus_resp    <= {BUS_DATA_WIDTH{1'b0}};
      bus_resptag <= {BUS_TAG_WIDTH{1'b0}};
      busy        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_xfer_s) begin
            base_r  <= idx_s[ADDR_W-1:LINE_OFF_W];
            start_r <= idx_s[LINE_OFF_W-1:0];
            cnt_r   <= {LINE_OFF_W{1'b0}};
            busy    <= 1'b1;
            if (bus_reqtag[TAG_WR_BIT]) begin
              state_r <= ST_WR_DATA;
            end else begin
              tag_r   <= bus_reqtag;
              wait_r  <= WAIT_W'(READ_LATENCY);
              state_r <= ST_RD_WAIT;
            end
          end
        end
        ST_WR_DATA: begin
          if (req_xfer_s) begin
            cnt_r <= cnt_r + LINE_OFF_W'(1);
            if (cnt_r == LAST_BEAT) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (wait_r <= WAIT_W'(1)) begin
            state_r     <= ST_RD_BURST;
            cnt_r       <= {LINE_OFF_W{1'b0}};
            bus_respcyc <= 1'b1;
            bus_resp    <= mem_rdata_s;
            bus_resptag <= tag_r;
          end else begin
            wait_r <= wait_r - WAIT_W'(1);
          end
        end
        ST_RD_BURST: begin
          // Beat is held until the initiator acknowledges it
          if (bus_respack) begin
            if (cnt_r == LAST_BEAT) begin
              state_r     <= ST_IDLE;
              busy        <= 1'b0;
              bus_respcyc <= 1'b0;
            end else begin
              cnt_r    <= cnt_r + LINE_OFF_W'(1);
              bus_resp <= mem_rdata_s;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy        <= 1'b0;
          bus_respcyc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized scoreboard bench for mem_bus_responder. The driver pushes
// expected read beats from a word-level memory model; an independent
// monitor pops and compares each acknowledged response beat.
`timescale 1ns/1ps
module tb_mem_bus_responder;

  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = 64'd0;
  logic [12:0] bus_reqtag = 13'd0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (65536),
    .READ_LATENCY   (RL),
    .BEATS          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .busy        (busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mdl [int];
  beat_t       exp_q [$];
  int          pool [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte address for word (line_word + start) with random junk above and below
  function automatic logic [63:0] mk_addr(input int line_word, input int start);
    logic [63:0] hi;
    hi = {32'($urandom), 32'($urandom)} & ~64'h7FFFF;
    return hi | (64'(line_word + start) << 3) | 64'($urandom_range(0, 7));
  endfunction

  // Random response back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_respack = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: compares acknowledged beats against the queue, checks that
  // a stalled beat holds still and that no request is taken during a read
  initial begin
    bit    stalled;
    beat_t held;
    beat_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (exp_q.size() > 0 && bus_reqcyc) chk("req_blocked_during_read", 64'(bus_reqack), 64'd0);
        if (stalled) begin
          chk("stall_valid", 64'(bus_respcyc), 64'd1);
          chk("stall_data", bus_resp, held.data);
          chk("stall_tag", 64'(bus_resptag), 64'(held.tag));
        end
        if (bus_respcyc && bus_respack) begin
          if (exp_q.size() == 0) begin
            chk("spurious_resp", 64'(bus_respcyc), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", bus_resp, e.data);
            chk("resp_tag", 64'(bus_resptag), 64'(e.tag));
          end
          stalled = 1'b0;
        end else if (bus_respcyc) begin
          stalled = 1'b1;
          held = {bus_resp, bus_resptag};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic send_addr(input logic [63:0] addr, input logic [12:0] tag);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus_reqack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_accept_timeout", 64'(bus_reqack), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int line_word, input int start, input logic [7:0][63:0] d);
    logic [12:0] t;
    t = 13'($urandom) | 13'h1000;
    send_addr(mk_addr(line_word, start), t);
    for (int b = 0; b < 8; b++) begin
      bus_req    = d[b];
      bus_reqtag = 13'($urandom);
      @(negedge clk);
      chk("wr_data_ack", 64'(bus_reqack), 64'd1);
      chk("wr_busy", 64'(busy), 64'd1);
      chk("wr_no_resp", 64'(bus_respcyc), 64'd0);
      @(posedge clk);
      #1;
      mdl[line_word + ((start + b) % 8)] = d[b];
    end
    bus_reqcyc = 1'b0;
    @(negedge clk);
    chk("wr_busy_clear", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input int line_word, input int start, input logic [11:0] id);
    int    lat;
    int    w;
    beat_t e;
    send_addr(mk_addr(line_word, start), {1'b0, id});
    for (int b = 0; b < 8; b++) begin
      w = line_word + ((start + b) % 8);
      e.data = mdl.exists(w) ? mdl[w] : 64'd0;
      e.tag  = {1'b0, id};
      exp_q.push_back(e);
    end
    bus_reqcyc = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (bus_respcyc) break;
      lat++;
    end
    chk("read_latency", 64'(lat), 64'(RL));
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][63:0] d;
    int               lw;
    int               guard;

    // Reset held with a request pending: IDLE acceptance visible, outputs quiet
    reset      = 1'b0;
    bus_reqcyc = 1'b1;
    bus_reqtag = 13'h0001;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_reqack", 64'(bus_reqack), 64'd1);
    chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp", bus_resp, 64'd0);
    chk("rst_resptag", 64'(bus_resptag), 64'd0);
    bus_reqcyc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Directed line at byte 0x1000 (words 0x200..0x207)
    for (int b = 0; b < 8; b++) d[b] = 64'((b + 1) * 8'h11);
    do_write(32'h200, 0, d);
    do_read(32'h200, 0, 12'h005);
    do_read(32'h200, 6, 12'h005);

    // Reset part-way through a burst
    do_read(32'h200, 0, 12'h0A7);
    guard = 0;
    while (exp_q.size() > 5 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_respcyc", 64'(bus_respcyc), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_read(32'h200, 3, 12'h0B3);

    // Random lines, randomized starts, data, ids
    for (int i = 0; i < 4; i++) begin
      lw = int'($urandom_range(0, 8191)) * 8;
      pool.push_back(lw);
      for (int b = 0; b < 8; b++) d[b] = {32'($urandom), 32'($urandom)};
      do_write(lw, int'($urandom_range(0, 7)), d);
    end
    for (int i = 0; i < 40; i++) begin
      lw = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 4) begin
        for (int b = 0; b < 8; b++) d[b] = {32'($urandom), 32'($urandom)};
        do_write(lw, int'($urandom_range(0, 7)), d);
      end else begin
        do_read(lw, int'($urandom_range(0, 7)), 12'($urandom));
      end
    end

    // Drain outstanding beats
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the shared 64-bit tagged request/response bus that the fetch-stage TLB and instruction/data caches drive as initiators. Accepts one line-sized read or write transaction at a time, holds a word-addressed backing store, and returns read data as an 8-beat, critical-word-first burst tagged with the requester's tag. Sits at the far end of the bus arbiters and stands in for DRAM in simulation and FPGA bring-up.

## Interface
- BUS_DATA_WIDTH, 64, data/address beat width
- BUS_TAG_WIDTH, 13, request/response tag width
- MEM_WORDS, 65536, backing-store depth in 64-bit words; power of two
- READ_LATENCY, 4, idle cycles between read accept and first response beat; ≥1
- BEATS, 8, beats per line (64-byte line)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- bus_reqcyc  in  1  initiator has a request beat valid
- bus_req  in  BUS_DATA_WIDTH  address beat (byte address) or write-data beat
- bus_reqtag  in  BUS_TAG_WIDTH  tag; bit 12 = 1 write, 0 read; bits 7:0 = requester id
- bus_reqack  out  1  request beat accepted this cycle
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  read-data beat
- bus_resptag  out  BUS_TAG_WIDTH  tag captured from the read request
- bus_respack  in  1  initiator consumes response beat this cycle
- busy  out  1  transaction in progress (state ≠ IDLE)

## Operation
- Beat transfer on a request: rising edge with bus_reqcyc && bus_reqack. Beat transfer on a response: rising edge with bus_respcyc && bus_respack.
- bus_reqack is combinational: bus_reqcyc && (state == IDLE || state == WR_DATA).
- Word index = bus_req[3 +: log2(MEM_WORDS)]; upper bits ignored (address wraps modulo store). Line base = index with low 3 bits cleared; start beat = bus_req[5:3].
- States: IDLE, WR_DATA, RD_WAIT, RD_BURST.
- IDLE: accepted beat with tag[12]=0 → capture tag, base, start beat; load wait counter with READ_LATENCY; → RD_WAIT. tag[12]=1 → capture base, start beat; beat counter = 0; → WR_DATA.
- WR_DATA: each accepted beat writes mem[base | ((start + cnt) mod 8)]; after 8th beat → IDLE. No response generated for writes. Tag on data beats ignored.
- RD_WAIT: counter decrements each cycle; at 1 → RD_BURST with cnt = 0.
- RD_BURST: bus_respcyc = 1, bus_resp = mem[base | ((start + cnt) mod 8)], bus_resptag = captured tag. Hold beat stable until bus_respack. Acked beat 7 → IDLE.
- Requests presented in RD_WAIT/RD_BURST are not acked (one outstanding transaction); initiator must hold bus_reqcyc.
- Backing store is not cleared by reset; optional $readmemh preload is a simulation-only hook.

## Timing
- Reset (reset == 0, asynchronous): state = IDLE, bus_reqack follows IDLE rule, bus_respcyc = 0, bus_resp = 0, bus_resptag = 0, busy = 0, counters = 0. Reset mid-burst or mid-write drops the transaction immediately; partial write beats already stored remain.
- Read latency: accept at edge T → bus_respcyc high after edge T + READ_LATENCY; with continuous bus_respack, last beat at edge T + READ_LATENCY + 8, IDLE after it; a new request may be acked in the following cycle.
- Write: address accept at edge T; data beats acked from cycle after T, one per cycle if bus_reqcyc held; busy drops after 8th data beat.
- Back-pressure: bus_respack low stalls the burst indefinitely; bus_resp/bus_resptag must not change while stalled.
- Start-beat wrap: start = 6 reads words base+6, +7, +0, …, +5.
- Read of a word written in the immediately preceding write returns the new data (write completes before read accept).

## Structure
- Shared bus package: tag bit positions (write flag, id field), BEATS, line-offset constants, state enum type.
- One sub-module natural: mem_bus_store (single-port 64-bit synchronous-write / async-read array, MEM_WORDS deep); FSM, counters and handshake logic stay in the top.

## Test plan
- Reset held low with bus_reqcyc = 1 → bus_reqack high combinationally (IDLE), bus_respcyc = 0, busy = 0; release → no spurious response.
- Write to address 0x1000, tag 0x1005, data 0x11..0x88 → 9 acks in 9 cycles, mem words 0x200–0x207 = 0x11..0x88, no bus_respcyc.
- Read 0x1000, tag 0x0005, READ_LATENCY 4 → first beat 4 cycles after accept, data 0x11..0x88 in order, bus_resptag = 0x0005 every beat.
- Read 0x1030 (start beat 6) → beats 0x77, 0x88, 0x11, …, 0x66.
- Stall: bus_respack low 3 cycles on beat 2 → bus_resp held at beat 2 value; second request during burst not acked until after beat 7.
- Assert reset mid-burst at beat 3 → bus_respcyc low same cycle; subsequent read returns full 8 beats correctly.
